// File: rtl/torrence_types_pkg.sv
// Shared types for the torrence cache/memory subsystem: memory operations,
// arbiter state encoding and requester identifiers.
package torrence_types;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    STORE   = 2'd1,
    CLFLUSH = 2'd2
  } memory_operation_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } hmem_arb_state_e;

  typedef logic [0:0] requester_id_t;

  // Beat counter width; a one-beat burst still needs a 1-bit register.
  function automatic int beat_cnt_width(input int beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/hmem_arb_perf_counter.sv
// Saturating event counter with enable and synchronous active-low reset.
module hmem_arb_perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hmem_arbiter.sv
// Two-requester burst arbiter (I-cache = 0, D-cache = 1) for the higher-level
// memory port. Optional perf counters are enabled with HMEM_ARB_PERF_CNT_EN.
module hmem_arbiter
  import torrence_types::*;
#(
  parameter int XLEN            = 32,
  parameter int BEATS_PER_BURST = 4,
  parameter int PERF_W          = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              r0_req_valid,
  input  memory_operation_e r0_req_operation,
  input  logic [XLEN-1:0]   r0_req_address,
  input  logic [XLEN-1:0]   r0_req_store_word,
  output logic              r0_req_fulfilled,
  input  logic              r1_req_valid,
  input  memory_operation_e r1_req_operation,
  input  logic [XLEN-1:0]   r1_req_address,
  input  logic [XLEN-1:0]   r1_req_store_word,
  output logic              r1_req_fulfilled,
  output logic [XLEN-1:0]   req_loaded_word,
  output logic              hmem_req_valid,
  output memory_operation_e hmem_req_operation,
  output logic [XLEN-1:0]   hmem_req_address,
  output logic [XLEN-1:0]   hmem_req_store_word,
  input  logic              hmem_req_fulfilled,
  input  logic [XLEN-1:0]   hmem_req_loaded_word,
  output logic              grant_id
`ifdef HMEM_ARB_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] r0_grant_count,
  output logic [PERF_W-1:0] r1_grant_count,
  output logic [PERF_W-1:0] r0_stall_cycles,
  output logic [PERF_W-1:0] r1_stall_cycles
`endif
);

  localparam int CNT_W = beat_cnt_width(BEATS_PER_BURST);

  if (BEATS_PER_BURST < 1 || BEATS_PER_BURST > 256) begin : g_bad_beats
    $error("BEATS_PER_BURST must be in 1..256");
  end
  if (PERF_W < 1) begin : g_bad_perf_w
    $error("PERF_W must be at least 1");
  end

  hmem_arb_state_e   state;
  requester_id_t     rr_ptr;
  logic [CNT_W-1:0]  beat_cnt;

  logic              any_valid;
  logic              ptr_valid;
  requester_id_t     winner;
  logic              g_valid;
  logic              last_beat;

  assign any_valid = r0_req_valid | r1_req_valid;
  assign ptr_valid = rr_ptr[0] ? r1_req_valid : r0_req_valid;
  assign winner    = ptr_valid ? rr_ptr : ~rr_ptr;
  assign g_valid   = grant_id ? r1_req_valid : r0_req_valid;
  assign last_beat = (beat_cnt == CNT_W'(BEATS_PER_BURST - 1));

  assign req_loaded_word = hmem_req_loaded_word;

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    hmem_req_valid      = 1'b0;
    hmem_req_operation  = LOAD;
    hmem_req_address    = '0;
    hmem_req_store_word = '0;
    r0_req_fulfilled    = 1'b0;
    r1_req_fulfilled    = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_BUSY: begin
        hmem_req_valid      = g_valid;
        hmem_req_operation  = grant_id ? r1_req_operation  : r0_req_operation;
        hmem_req_address    = grant_id ? r1_req_address    : r0_req_address;
        hmem_req_store_word = grant_id ? r1_req_store_word : r0_req_store_word;
        r0_req_fulfilled    = !grant_id && g_valid && hmem_req_fulfilled;
        r1_req_fulfilled    =  grant_id && g_valid && hmem_req_fulfilled;
      end
      default: begin
        hmem_req_valid      = 1'bx;
        hmem_req_operation  = memory_operation_e'('x);
        hmem_req_address    = 'x;
        hmem_req_store_word = 'x;
        r0_req_fulfilled    = 1'bx;
        r1_req_fulfilled    = 1'bx;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant_id <= 1'b0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            grant_id <= winner[0];
            beat_cnt <= '0;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Dropping valid abandons the burst; the partial beat is not counted.
          if (!g_valid) begin
            state  <= ST_IDLE;
            rr_ptr <= ~grant_id;
          end else if (hmem_req_fulfilled) begin
            if (last_beat) begin
              state  <= ST_IDLE;
              rr_ptr <= ~grant_id;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  spurious_fulfilled_a : assert property (@(posedge clk) disable iff (!reset_n)
    !(hmem_req_fulfilled && !hmem_req_valid))
    else $warning("hmem_req_fulfilled seen without hmem_req_valid; beat ignored");

`ifdef HMEM_ARB_PERF_CNT_EN
  logic grant_evt;
  assign grant_evt = (state == ST_IDLE) && any_valid;

  hmem_arb_perf_counter #(.W(PERF_W)) u_r0_grants (
    .clk(clk), .reset_n(reset_n), .en(grant_evt && !winner[0]), .count(r0_grant_count));
  hmem_arb_perf_counter #(.W(PERF_W)) u_r1_grants (
    .clk(clk), .reset_n(reset_n), .en(grant_evt && winner[0]), .count(r1_grant_count));
  hmem_arb_perf_counter #(.W(PERF_W)) u_r0_stalls (
    .clk(clk), .reset_n(reset_n),
    .en(r0_req_valid && !((state == ST_BUSY) && !grant_id)), .count(r0_stall_cycles));
  hmem_arb_perf_counter #(.W(PERF_W)) u_r1_stalls (
    .clk(clk), .reset_n(reset_n),
    .en(r1_req_valid && !((state == ST_BUSY) && grant_id)), .count(r1_stall_cycles));
`endif

endmodule

// File: tb/tb_hmem_arbiter.sv
// Self-checking bench for hmem_arbiter: directed scenarios plus randomized
// traffic, compared every cycle against a transaction-level ownership model.
module tb_hmem_arbiter;
  import torrence_types::*;

  localparam int XLEN   = 32;
  localparam int BEATS  = 4;
  localparam int PERF_W = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              r0_req_valid, r1_req_valid;
  memory_operation_e r0_req_operation, r1_req_operation;
  logic [XLEN-1:0]   r0_req_address, r1_req_address;
  logic [XLEN-1:0]   r0_req_store_word, r1_req_store_word;
  logic              r0_req_fulfilled, r1_req_fulfilled;
  logic [XLEN-1:0]   req_loaded_word;
  logic              hmem_req_valid;
  memory_operation_e hmem_req_operation;
  logic [XLEN-1:0]   hmem_req_address, hmem_req_store_word;
  logic              hmem_req_fulfilled;
  logic [XLEN-1:0]   hmem_req_loaded_word;
  logic              grant_id;
`ifdef HMEM_ARB_PERF_CNT_EN
  logic [PERF_W-1:0] r0_grant_count, r1_grant_count, r0_stall_cycles, r1_stall_cycles;
`endif

  always #5 clk = ~clk;

  hmem_arbiter #(.XLEN(XLEN), .BEATS_PER_BURST(BEATS), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_req_valid(r0_req_valid), .r0_req_operation(r0_req_operation),
    .r0_req_address(r0_req_address), .r0_req_store_word(r0_req_store_word),
    .r0_req_fulfilled(r0_req_fulfilled),
    .r1_req_valid(r1_req_valid), .r1_req_operation(r1_req_operation),
    .r1_req_address(r1_req_address), .r1_req_store_word(r1_req_store_word),
    .r1_req_fulfilled(r1_req_fulfilled),
    .req_loaded_word(req_loaded_word),
    .hmem_req_valid(hmem_req_valid), .hmem_req_operation(hmem_req_operation),
    .hmem_req_address(hmem_req_address), .hmem_req_store_word(hmem_req_store_word),
    .hmem_req_fulfilled(hmem_req_fulfilled), .hmem_req_loaded_word(hmem_req_loaded_word),
    .grant_id(grant_id)
`ifdef HMEM_ARB_PERF_CNT_EN
    , .r0_grant_count(r0_grant_count), .r1_grant_count(r1_grant_count)
    , .r0_stall_cycles(r0_stall_cycles), .r1_stall_cycles(r1_stall_cycles)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the port, beats delivered so far, who is preferred next.
  int owner = -1;
  int beats_done = 0;
  int pref = 0;
  int ful_seen[2] = '{0, 0};
  int ful_mode = 0;  // 0 none, 1 every valid beat, 2 random valid beats, 3 forced high
  int m_grants[2] = '{0, 0};
  int m_stalls[2] = '{0, 0};
  localparam int PERF_MAX = (1 << PERF_W) - 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic req_v(input int n);
    return (n == 0) ? r0_req_valid : r1_req_valid;
  endfunction

  task automatic set_req(input int n, input logic v, input memory_operation_e op,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] s);
    if (n == 0) begin
      r0_req_valid = v; r0_req_operation = op; r0_req_address = a; r0_req_store_word = s;
    end else begin
      r1_req_valid = v; r1_req_operation = op; r1_req_address = a; r1_req_store_word = s;
    end
  endtask

  // One clock: memory response, compare outputs, clock edge, advance the model.
  task automatic step();
    logic ev, ef0, ef1;
    memory_operation_e eo;
    logic [XLEN-1:0] ea, es;
    ev = (owner >= 0) ? req_v(owner) : 1'b0;
    case (ful_mode)
      1:       hmem_req_fulfilled = ev;
      2:       hmem_req_fulfilled = ev && ($urandom_range(0, 1) == 1);
      3:       hmem_req_fulfilled = 1'b1;
      default: hmem_req_fulfilled = 1'b0;
    endcase
    hmem_req_loaded_word = $urandom();
    eo  = (owner == 0) ? r0_req_operation  : (owner == 1) ? r1_req_operation  : LOAD;
    ea  = (owner == 0) ? r0_req_address    : (owner == 1) ? r1_req_address    : '0;
    es  = (owner == 0) ? r0_req_store_word : (owner == 1) ? r1_req_store_word : '0;
    ef0 = (owner == 0) && ev && hmem_req_fulfilled;
    ef1 = (owner == 1) && ev && hmem_req_fulfilled;
    #1;
    check("hmem_valid", hmem_req_valid, ev);
    check("hmem_op", hmem_req_operation, eo);
    check("hmem_addr", hmem_req_address, ea);
    check("hmem_store", hmem_req_store_word, es);
    check("r0_fulfilled", r0_req_fulfilled, ef0);
    check("r1_fulfilled", r1_req_fulfilled, ef1);
    check("loaded_word", req_loaded_word, hmem_req_loaded_word);
    if (owner >= 0) check("grant_id", 64'(grant_id), 64'(owner));
`ifdef HMEM_ARB_PERF_CNT_EN
    check("r0_grant_count", r0_grant_count, m_grants[0]);
    check("r1_grant_count", r1_grant_count, m_grants[1]);
    check("r0_stall_cycles", r0_stall_cycles, m_stalls[0]);
    check("r1_stall_cycles", r1_stall_cycles, m_stalls[1]);
`endif
    ful_seen[0] += r0_req_fulfilled ? 1 : 0;
    ful_seen[1] += r1_req_fulfilled ? 1 : 0;
    @(posedge clk);
    if (!reset_n) begin
      owner = -1; beats_done = 0; pref = 0;
      m_grants = '{0, 0}; m_stalls = '{0, 0};
    end else begin
      for (int n = 0; n < 2; n++)
        if (req_v(n) && owner != n && m_stalls[n] < PERF_MAX) m_stalls[n]++;
      if (owner < 0) begin
        if (r0_req_valid || r1_req_valid) begin
          owner = req_v(pref) ? pref : 1 - pref;
          beats_done = 0;
          if (m_grants[owner] < PERF_MAX) m_grants[owner]++;
        end
      end else if (!req_v(owner)) begin
        pref = 1 - owner; owner = -1;
      end else if (hmem_req_fulfilled) begin
        beats_done++;
        if (beats_done == BEATS) begin
          pref = 1 - owner; owner = -1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int base[2];
    reset_n = 1'b0;
    set_req(0, 1'b0, LOAD, '0, '0);
    set_req(1, 1'b0, LOAD, '0, '0);
    hmem_req_fulfilled = 1'b0;
    hmem_req_loaded_word = '0;
    @(negedge clk);
    #1;
    check("reset_hmem_valid", hmem_req_valid, 1'b0);
    check("reset_hmem_op", hmem_req_operation, LOAD);
    check("reset_grant_id", grant_id, 1'b0);
    do_reset();

    // Lone r0 burst: 1-cycle latency, exactly four pulses, r1 untouched.
    ful_mode = 1;
    ful_seen = '{0, 0};
    set_req(0, 1'b1, LOAD, 32'h100, '0);
    for (int i = 0; i < 8; i++) begin
      if (ful_seen[0] >= BEATS) r0_req_valid = 1'b0;
      step();
    end
    check("s1_r0_beats", ful_seen[0], BEATS);
    check("s1_r1_beats", ful_seen[1], 0);
    ful_mode = 0;
    set_req(0, 1'b1, LOAD, 32'h104, '0);
    set_req(1, 1'b1, LOAD, 32'h204, '0);
    step();
    check("s1_next_goes_r1", grant_id, 1'b1);

    // Both valid out of reset: r0 first, one bubble, then r1's store.
    do_reset();
    ful_mode = 1;
    set_req(0, 1'b1, LOAD, 32'h104, '0);
    set_req(1, 1'b1, STORE, 32'h200, 32'hDEADBEEF);
    step();
    check("s2_first_r0", grant_id, 1'b0);
    repeat (BEATS) step();
    r0_req_valid = 1'b0;
    ful_mode = 0;
    #1 check("s2_bubble", hmem_req_valid, 1'b0);
    step();
    #1;
    check("s2_r1_addr", hmem_req_address, 32'h200);
    check("s2_r1_word", hmem_req_store_word, 32'hDEADBEEF);
    check("s2_r1_op", hmem_req_operation, STORE);

    // r1 owns; r0 toggles without effect; r1 abandons after two beats.
    ful_mode = 1;
    ful_seen = '{0, 0};
    r0_req_valid = 1'b1;
    step();
    r0_req_valid = 1'b0;
    step();
    check("s3_r1_two_beats", ful_seen[1], 2);
    r1_req_valid = 1'b0;
    r0_req_valid = 1'b1;
    step();
    step();
    check("s3_r0_after_abandon", grant_id, 1'b0);

    // Mid-burst reset after two beats; the next grant needs a full burst.
    do_reset();
    set_req(0, 1'b1, LOAD, 32'h300, '0);
    set_req(1, 1'b0, LOAD, 32'h400, '0);
    step();
    repeat (2) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    ful_mode = 0;
    r1_req_valid = 1'b1;
    #1 check("s4_idle_after_reset", hmem_req_valid, 1'b0);
    step();
    check("s4_rr_back_to_r0", grant_id, 1'b0);
    ful_mode = 1;
    repeat (BEATS - 1) step();
    #1 check("s4_still_owned", hmem_req_valid, 1'b1);
    step();
    #1 check("s4_released", hmem_req_valid, 1'b0);

    // Spurious fulfilled with no request outstanding.
    set_req(0, 1'b0, LOAD, '0, '0);
    set_req(1, 1'b0, LOAD, '0, '0);
    repeat (3) step();
    ful_mode = 3;
    step();
    ful_mode = 1;

    // Randomized traffic with abandons and occasional resets.
    ful_mode = 2;
    base = '{0, 0};
    for (int c = 0; c < 1500; c++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      for (int n = 0; n < 2; n++) begin
        if (!req_v(n)) begin
          if ($urandom_range(0, 3) == 0) begin
            set_req(n, 1'b1, memory_operation_e'($urandom_range(0, 2)), $urandom(), $urandom());
            base[n] = ful_seen[n];
          end
        end else if (ful_seen[n] - base[n] >= BEATS || $urandom_range(0, 29) == 0) begin
          set_req(n, 1'b0, LOAD, $urandom(), $urandom());
        end
      end
      step();
    end
    reset_n = 1'b1;

`ifdef HMEM_ARB_PERF_CNT_EN
    // r0 holds the port forever; r1 stalls 20 cycles and saturates.
    do_reset();
    ful_mode = 0;
    set_req(0, 1'b1, LOAD, 32'h500, '0);
    set_req(1, 1'b0, LOAD, '0, '0);
    step();
    r1_req_valid = 1'b1;
    repeat (20) step();
    #1;
    check("perf_r1_stall_sat", r1_stall_cycles, 4'hF);
    check("perf_r0_grants", r0_grant_count, 4'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hmem_arbiter.md
Name: hmem_arbiter

Overview:
- Shares one higher-level memory port between two cache controllers: requester 0 is the instruction cache and requester 1 is the data cache.
- Grants whole line bursts, so refill, writeback and flush beats from one cache are never interleaved with the other cache's beats.
- Round-robin between requesters; no combinational path from hmem_req_fulfilled back to grant selection.
- Sits between the cache controllers' requester ports and the memory controller / bus bridge.

Parameters:
XLEN, 32, address and data word width
BEATS_PER_BURST, 4, words per cache line, i.e. fulfilled beats per grant; legal range 1..256
PERF_W, 32, perf counter width (used only with the optional feature)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset, sampled on posedge clk
r0_req_valid  in  1  requester 0 request valid; held high for the whole burst
r0_req_operation  in  memory_operation_e  LOAD/STORE/CLFLUSH
r0_req_address  in  XLEN  beat address
r0_req_store_word  in  XLEN  store data
r0_req_fulfilled  out  1  beat done for requester 0
r1_req_valid, r1_req_operation, r1_req_address, r1_req_store_word, r1_req_fulfilled: same as r0_*, for requester 1
req_loaded_word  out  XLEN  load data, broadcast to both requesters
hmem_req_valid  out  1  request to memory
hmem_req_operation  out  memory_operation_e  forwarded operation
hmem_req_address  out  XLEN  forwarded address
hmem_req_store_word  out  XLEN  forwarded store data
hmem_req_fulfilled  in  1  memory beat done
hmem_req_loaded_word  in  XLEN  memory load data
grant_id  out  1  current owner (valid in ST_BUSY)

Behaviour:
- States:
  - ST_IDLE: no owner.
  - ST_BUSY: one owner.
  - default: x-propagate all outputs, same as the team's other FSMs.
- Reset (reset_n low at posedge):
  - state=ST_IDLE, rr_ptr=0, grant_id=0, beat_cnt=0.
  - Outputs: hmem_req_valid=0, hmem_req_operation=LOAD, hmem address and store word=0, r0/r1_req_fulfilled=0.
  - A mid-burst reset drops the grant immediately and discards the beat count.
- ST_IDLE:
  - If any rN_req_valid is high: winner = rr_ptr if that requester is valid, else the other one. Register grant_id=winner, beat_cnt=0, go to ST_BUSY.
  - If both are valid, rr_ptr decides.
  - Request-to-hmem_req_valid latency is exactly 1 cycle.
- ST_BUSY, Moore/mux outputs:
  - hmem_req_valid, operation, address and store word are combinational muxes of the granted requester's inputs.
  - Operation is forwarded unchanged.
- ST_BUSY, Mealy outputs:
  - r[grant_id]_req_fulfilled = hmem_req_fulfilled & hmem_req_valid.
  - The non-granted fulfilled output is always 0.
  - req_loaded_word = hmem_req_loaded_word in every state.
- ST_BUSY, beat counting:
  - beat_cnt increments on each fulfilled beat.
- ST_BUSY exits:
  - Burst done: fulfilled beat with beat_cnt==BEATS_PER_BURST-1. Go to ST_IDLE, rr_ptr = ~grant_id.
  - Abandon: granted req_valid low. Go to ST_IDLE, rr_ptr = ~grant_id; no beat is counted.
- The release cycle always returns to ST_IDLE, giving a one-cycle bubble.
- Writeback followed by allocate is two separate bursts. If the other requester is waiting, it wins between them.
- hmem_req_fulfilled while hmem_req_valid=0 is ignored. Flagged by assertion.
- Input and output widths match exactly; beat_cnt width = max(1, $clog2(BEATS_PER_BURST)).
- Fairness: a continuously valid requester is granted within one burst plus 1 cycle of the other requester releasing.

Optional Feature:
HMEM_ARB_PERF_CNT_EN
- Defined: adds output ports r0_grant_count, r1_grant_count, r0_stall_cycles, r1_stall_cycles (each PERF_W).
  - grant_count increments on each ST_IDLE->ST_BUSY grant to that requester.
  - stall_cycles increments each cycle rN_req_valid=1 while the arbiter is not in ST_BUSY owned by N.
  - All counters saturate at all-ones and reset to 0.
- Undefined: these ports and their logic are absent; the remaining behaviour is identical.

Decomposition:
- torrence_types package:
  - memory_operation_e: reused unchanged.
  - new hmem_arb_state_e {ST_IDLE=1'b0, ST_BUSY=1'b1}.
  - new typedef requester_id_t (logic [0:0]).
- Sub-module hmem_arb_perf_counter: one saturating counter with enable. Instantiated four times, only under the macro.

Test Plan:
- Only r0 valid (LOAD, addr 0x100), memory fulfils 4 beats: hmem_req_valid rises 1 cycle later; r0_req_fulfilled pulses 4 times; back in ST_IDLE with rr_ptr=1; r1_req_fulfilled stays 0.
- r0 and r1 both valid out of reset: r0 is granted for 4 beats. Bubble cycle with hmem_req_valid=0, then r1 (STORE, addr 0x200, data 0xDEADBEEF) appears on the hmem port.
- r1 owns the port, r0 drops req_valid while r1 holds: no effect. Then r1 drops valid after 2 beats: abandon, ST_IDLE; the next grant goes to r0 if valid.
- reset_n low mid-burst after beat 2: next cycle hmem_req_valid=0, state ST_IDLE, rr_ptr=0. The following grant restarts beat_cnt at 0.
- Memory asserts hmem_req_fulfilled with hmem_req_valid=0: no fulfilled pulse, beat_cnt unchanged, assertion fires.
- With HMEM_ARB_PERF_CNT_EN and PERF_W=4: r1 stalls 20 cycles; r1_stall_cycles=15, saturated, and r0_grant_count increments per burst.
